// File: rtl/mux_pkg.sv
// Shared constants for the 32-bit mux/demux datapath blocks.
package mux_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 16;

endpackage : mux_pkg

// File: rtl/stream_fifo.sv
// Small registered FIFO with occupancy counter; push is ignored when full, pop when empty.
module stream_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (occ_q == OCC_W'(DEPTH));
  assign empty     = (occ_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is cleared on reset so an idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule : stream_fifo

// File: rtl/demux1t2_32_stream.sv
// Buffered 1-to-2 stream demultiplexer: steers each accepted word into one of two
// independent output FIFOs and counts words delivered on each port.
module demux1t2_32_stream
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] out0_cnt,
  output logic [CNT_W-1:0] out1_cnt
);

  logic             full0, full1;
  logic             empty0, empty1;
  logic             accept;
  logic             push0, push1;
  logic             pop0, pop1;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Ready depends only on the selected FIFO, so a stalled port never blocks the other.
  assign in_ready = in_sel ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && !in_sel;
  assign push1    = accept &&  in_sel;

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .head_data (out0_data),
    .full      (full0),
    .empty     (empty0)
  );

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .head_data (out1_data),
    .full      (full1),
    .empty     (empty1)
  );

  // Delivery counters wrap modulo 2^CNT_W.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) cnt0_d = cnt0_q + CNT_W'(1);
    if (pop1) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign out0_cnt = cnt0_q;
  assign out1_cnt = cnt1_q;

endmodule : demux1t2_32_stream

// File: tb/tb_demux1t2_32_stream.sv
// Randomised self-checking bench for demux1t2_32_stream against a queue-based model.
module tb_demux1t2_32_stream;

  localparam int unsigned W = 32;
  localparam int unsigned D = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out0_data, out1_data;
  logic          out0_valid, out1_valid;
  logic          out0_ready, out1_ready;
  logic [15:0]   out0_cnt, out1_cnt;

  logic [W-1:0]  q0[$];
  logic [W-1:0]  q1[$];
  logic [15:0]   cnt0, cnt1;
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  demux1t2_32_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out0_cnt   (out0_cnt),
    .out1_cnt   (out1_cnt)
  );

  // Model: advance one clock, applying pops (pre-edge contents) then the accepted push.
  task automatic tick(output bit acc);
    bit p0, p1;
    acc = in_valid && (in_sel ? (q1.size() < D) : (q0.size() < D));
    p0  = out0_ready && (q0.size() != 0);
    p1  = out1_ready && (q1.size() != 0);
    @(posedge clk);
    if (p0) begin void'(q0.pop_front()); cnt0 = cnt0 + 16'd1; end
    if (p1) begin void'(q1.pop_front()); cnt1 = cnt1 + 16'd1; end
    if (acc) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
    end
    #1;
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    cnt0 = '0;
    cnt1 = '0;
  endtask

  task automatic test_reset();
    bit acc;
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = $urandom;
      tick(acc);
    end
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out0_valid !== 1'b1 || out0_data !== q0[0]) begin
      miscompares++;
      $display("FAIL rst_pre_head: got valid=%0b data=%h exp valid=1 data=%h", out0_valid, out0_data, q0[0]);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pre_full: got in_ready=%0b exp 0", in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    vectors++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_valid: got %0b/%0b exp 0/0", out0_valid, out1_valid);
    end
    vectors++;
    if (out0_data !== '0 || out1_data !== '0) begin
      miscompares++;
      $display("FAIL rst_data: got %h/%h exp 0/0", out0_data, out1_data);
    end
    vectors++;
    if (out0_cnt !== 16'd0 || out1_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_cnt: got %0d/%0d exp 0/0", out0_cnt, out1_cnt);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_ready: got %0b exp 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_routing();
    bit acc;
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEADBEEF;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL route_ready: got %0b exp 1", in_ready);
    end
    tick(acc);
    in_sel = 1'b1; in_data = 32'h12345678;
    vectors++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hDEADBEEF || out1_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL route_p0: got v0=%0b d0=%h v1=%0b exp v0=1 d0=deadbeef v1=0", out0_valid, out0_data, out1_valid);
    end
    tick(acc);
    in_valid = 1'b0;
    vectors++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h12345678 || out0_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL route_p1: got v1=%0b d1=%h v0=%0b exp v1=1 d1=12345678 v0=0", out1_valid, out1_data, out0_valid);
    end
    tick(acc);
    vectors++;
    if (out0_cnt !== 16'd1 || out1_cnt !== 16'd1 || out1_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL route_cnt: got cnt=%0d/%0d v1=%0b exp 1/1 v1=0", out0_cnt, out1_cnt, out1_valid);
    end
  endtask

  task automatic test_full();
    bit acc;
    logic [W-1:0] w [3];
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      in_data = w[i];
      #1;
      vectors++;
      if (in_ready !== (i < 2)) begin
        miscompares++;
        $display("FAIL full_ready%0d: got %0b exp %0b", i, in_ready, (i < 2));
      end
      tick(acc);
    end
    in_sel = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_other_ready: got %0b exp 1", in_ready);
    end
    tick(acc);
    in_valid = 1'b0;
    vectors++;
    if (out1_valid !== 1'b1 || out1_data !== w[2]) begin
      miscompares++;
      $display("FAIL full_other_data: got v=%0b d=%h exp v=1 d=%h", out1_valid, out1_data, w[2]);
    end
    vectors++;
    if (out0_valid !== 1'b1 || out0_data !== w[0]) begin
      miscompares++;
      $display("FAIL full_hold: got v=%0b d=%h exp v=1 d=%h", out0_valid, out0_data, w[0]);
    end
    out0_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (out0_valid !== 1'b1 || out0_data !== w[i]) begin
        miscompares++;
        $display("FAIL full_drain%0d: got v=%0b d=%h exp v=1 d=%h", i, out0_valid, out0_data, w[i]);
      end
      tick(acc);
    end
    vectors++;
    if (out0_valid !== 1'b0 || out0_cnt !== cnt0) begin
      miscompares++;
      $display("FAIL full_empty: got v=%0b cnt=%0d exp v=0 cnt=%0d", out0_valid, out0_cnt, cnt0);
    end
  endtask

  task automatic test_simul_push_pop();
    bit acc;
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = a;
    tick(acc);
    out1_ready = 1'b1; in_data = b;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out1_valid !== 1'b1 || out1_data !== a) begin
      miscompares++;
      $display("FAIL simul_pre: got rdy=%0b v=%0b d=%h exp rdy=1 v=1 d=%h", in_ready, out1_valid, out1_data, a);
    end
    tick(acc);
    in_valid = 1'b0;
    vectors++;
    if (out1_valid !== 1'b1 || out1_data !== b || q1.size() != 1) begin
      miscompares++;
      $display("FAIL simul_occ1: got v=%0b d=%h exp v=1 d=%h", out1_valid, out1_data, b);
    end
    tick(acc);
    vectors++;
    if (out1_valid !== 1'b0 || out1_cnt !== cnt1) begin
      miscompares++;
      $display("FAIL simul_drain: got v=%0b cnt=%0d exp v=0 cnt=%0d", out1_valid, out1_cnt, cnt1);
    end
  endtask

  task automatic test_random();
    bit acc;
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(3) != 0);
        in_sel   = 1'($urandom_range(1));
        in_data  = $urandom;
      end
      out0_ready = ($urandom_range(2) != 0);
      out1_ready = ($urandom_range(3) == 0);
      #1;
      vectors++;
      if (in_ready !== (in_sel ? (q1.size() < D) : (q0.size() < D))) begin
        miscompares++;
        $display("FAIL rand_ready c%0d: got %0b", c, in_ready);
      end
      vectors++;
      if (out0_valid !== (q0.size() != 0) || (q0.size() != 0 && out0_data !== q0[0])) begin
        miscompares++;
        $display("FAIL rand_out0 c%0d: got v=%0b d=%h exp v=%0b", c, out0_valid, out0_data, (q0.size() != 0));
      end
      vectors++;
      if (out1_valid !== (q1.size() != 0) || (q1.size() != 0 && out1_data !== q1[0])) begin
        miscompares++;
        $display("FAIL rand_out1 c%0d: got v=%0b d=%h exp v=%0b", c, out1_valid, out1_data, (q1.size() != 0));
      end
      vectors++;
      if (out0_cnt !== cnt0 || out1_cnt !== cnt1) begin
        miscompares++;
        $display("FAIL rand_cnt c%0d: got %0d/%0d exp %0d/%0d", c, out0_cnt, out1_cnt, cnt0, cnt1);
      end
      tick(acc);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    bit acc;
    int sent;
    int cycles;
    sent = 0; cycles = 0;
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out1_ready = 1'b1;
    in_sel = 1'b0; in_valid = 1'b1; in_data = $urandom;
    while (sent < 32'h10001 && cycles < 80000) begin
      out0_ready = ($urandom_range(31) != 0);
      #1;
      vectors++;
      if (in_ready !== (q0.size() < D) || out0_valid !== (q0.size() != 0)
          || (q0.size() != 0 && out0_data !== q0[0]) || out0_cnt !== cnt0) begin
        miscompares++;
        $display("FAIL wrap_cycle%0d: got rdy=%0b v=%0b d=%h cnt=%0d exp cnt=%0d", cycles, in_ready, out0_valid, out0_data, out0_cnt, cnt0);
      end
      tick(acc);
      cycles++;
      if (acc) begin
        sent++;
        if (sent == 32'h10001) in_valid = 1'b0;
        else in_data = $urandom;
      end
    end
    vectors++;
    if (sent != 32'h10001) begin
      miscompares++;
      $display("FAIL wrap_timeout: got %0d words sent exp %0d", sent, 32'h10001);
    end
    in_valid = 1'b0;
    out0_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(acc);
    vectors++;
    if (out0_cnt !== 16'd1 || cnt0 !== 16'd1 || out0_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_cnt: got cnt=%0d v=%0b exp cnt=1 v=0", out0_cnt, out0_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || in_ready !== 1'b1 || out0_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL por_state: got v=%0b/%0b rdy=%0b cnt=%0d exp 0/0 1 0", out0_valid, out1_valid, in_ready, out0_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_routing();
    test_full();
    test_simul_push_pop();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_demux1t2_32_stream

// File: doc/demux1t2_32_stream.md
# demux1t2_32_stream

Buffered 1-to-2 stream demultiplexer for the 32-bit datapath. It performs the inverse routing of the 2-to-1 data-select mux: one producer word is steered to one of two consumers by a select bit. Each destination has a small registered FIFO with a valid/ready handshake, so a stalled consumer never corrupts the other path. It sits between a single result producer and two independent sinks, for example a register write-back path and an I/O or bus write path.

## Interface
- `WIDTH`, default 32: data width in bits.
- `DEPTH`, default 2: entries per output FIFO; power of two, minimum 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_data`  in  WIDTH: word to route.
- `in_sel`  in  1: destination select; 0 routes to out0, 1 routes to out1.
- `in_valid`  in  1: producer offers `in_data` and `in_sel`.
- `in_ready`  out  1: the block accepts the offered word this cycle.
- `out0_data`, `out1_data`  out  WIDTH: head entry of each FIFO.
- `out0_valid`, `out1_valid`  out  1: the FIFO is non-empty.
- `out0_ready`, `out1_ready`  in  1: the consumer takes the head entry.
- `out0_cnt`, `out1_cnt`  out  16: count of words delivered on each port; wraps from 0xFFFF to 0.

## Operation
- **Accept.** A word is accepted when `in_valid && in_ready`.
  - `in_ready = !full[in_sel]`, a combinational function of `in_sel` and FIFO state only.
  - The producer holds `in_data` and `in_sel` stable while `in_valid` is high and `in_ready` is low.
- **Route.** An accepted word is pushed into FIFO `in_sel` only. The other FIFO is untouched.
- **Deliver.** A pop on port N occurs when `outN_valid && outN_ready`. On each pop, `outN_cnt` increments by 1.
- **Per-FIFO state.**
  - Read pointer and write pointer, each `log2(DEPTH)` bits and wrapping modulo `DEPTH`.
  - Occupancy counter, range 0..`DEPTH`.
  - `full` when occupancy equals `DEPTH`; `empty` when occupancy is 0.
- **Push and pop in the same cycle on the same FIFO.**
  - Both take effect and occupancy is unchanged.
  - This is legal only when the FIFO is not full, because a full FIFO deasserts `in_ready`.
  - There is no fall-through on full.
- **Pop from an empty FIFO** cannot occur, because `outN_valid` is low.
- **Ports are independent.** Back-pressure on one port never blocks words routed to the other port.
- **Ordering.** Order is preserved within each port. There is no ordering guarantee across ports.
- **Data outputs.** `outN_data` shows the storage entry at the read pointer. When the FIFO is empty, the value is the last popped word, or 0 after reset. Consumers ignore it while `outN_valid` is low.

## Timing
- **Reset (asynchronous, `rst_n` low).**
  - Pointers, occupancies, `out0_cnt` and `out1_cnt` clear to 0 immediately.
  - `out0_valid` and `out1_valid` are 0.
  - Storage clears to 0, so `out0_data` and `out1_data` are 0.
  - `in_ready` is 1, since neither FIFO is full.
- **Reset mid-operation.** All buffered words are discarded. Counts restart at 0.
- **Release.** Reset release is synchronised by the system. The first accept can occur on the first rising edge after `rst_n` goes high.
- **Latency.** A word accepted at edge k gives `outN_valid` = 1 with that word after edge k. That is one cycle latency, with no combinational path from input to output.
- **Throughput.** One word per cycle into an unstalled port. With a continuously ready consumer and `DEPTH` ≥ 2, occupancy never exceeds 1.
- **Count timing.** `outN_cnt` updates at the same edge as the pop it counts.
- **Combinational path.** `in_ready` goes low in the same cycle that `in_sel` points at a full FIFO.

## Structure
- **Shared package `mux_pkg`:**
  - `DATA_W = 32`.
  - Default `FIFO_DEPTH = 2`.
  - `CNT_W = 16`.
- **Sub-module `stream_fifo`**, parameterised by `WIDTH` and `DEPTH`.
  - Ports: `clk`, `rst_n`, `push`, `push_data`, `pop`, `head_data`, `full`, `empty`.
  - It is instantiated twice.
- **Top level** holds the select decode, the `in_ready` logic and the two delivery counters.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-traffic, with FIFO0 holding 2 words.
  - Outputs immediately show valids 0, data 0, counts 0 and `in_ready` = 1.
- **Routing:** push 0xDEADBEEF with sel = 0, then 0x12345678 with sel = 1, both consumers ready.
  - Each word appears one cycle after its accept, on the correct port only.
  - Counts become 1 and 1.
- **Full / back-pressure:** hold `out0_ready` = 0 and push 3 words with sel = 0.
  - The first 2 are accepted and `in_ready` drops on the 3rd.
  - With sel switched to 1, `in_ready` returns to 1 and the word reaches out1.
- **Simultaneous push/pop:** with FIFO1 holding 1 word, push to sel = 1 while `out1_ready` = 1.
  - Occupancy stays 1.
  - Words emerge in order across the following cycles.
- **Wrap-around:** send 0x10001 words through port 0 with random ready stalls.
  - Data sequence matches a scoreboard.
  - `out0_cnt` ends at 1, after wrapping past 0xFFFF.
